// File: rtl/uart_tx_fifo_if.sv
// Handshake and status bundle between the APB transmit-data write path,
// the transmit FIFO and the transmitter state machine.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  fifo_clr;
  logic                  fifo_write_n;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_read_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overflow;

  // Producer/consumer side: drives strobes and write data, observes status.
  modport master (
    output fifo_clr, fifo_write_n, data_in, fifo_read_n,
    input  data_out, fifo_empty, fifo_full, fifo_count, overflow
  );

  // FIFO side.
  modport slave (
    input  fifo_clr, fifo_write_n, data_in, fifo_read_n,
    output data_out, fifo_empty, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: active-low write/read strobes, registered head byte,
// count-decoded empty/full flags and a one-cycle overflow pulse on a
// dropped write. No fall-through: a byte written into an empty FIFO only
// reaches data_out through a later read.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  // Storage: no reset, contents are meaningless while count says empty.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;

  logic empty_w;
  logic full_w;
  logic wr_req;
  logic rd_req;
  logic rd_acc;
  logic wr_acc;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == FULL_COUNT);
  assign wr_req  = ~bus.fifo_write_n;
  assign rd_req  = ~bus.fifo_read_n;

  // A read needs data; a write needs room, or a slot freed by a same-cycle read.
  // A flush cancels both.
  assign rd_acc = ~bus.fifo_clr & rd_req & ~empty_w;
  assign wr_acc = ~bus.fifo_clr & wr_req & (~full_w | rd_acc);

  // Next-state for pointers, count, head byte and overflow pulse.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = 1'b0;

    if (bus.fifo_clr) begin
      // data_out deliberately keeps the last byte handed to the transmitter.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        data_out_d = mem_q[rd_ptr_q];
      end
      if (wr_acc && !rd_acc) begin
        count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - 1'b1;
      end
      overflow_d = wr_req & ~wr_acc;
    end
  end

  // Control state register with asynchronous flush on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Memory write port; a same-address read in this cycle sees the old byte.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.fifo_empty = empty_w;
  assign bus.fifo_full  = full_w;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the stimulus queues the byte each read
// strobe should produce; a monitor pops and compares one cycle after it.
module tb_uart_tx_fifo;

  logic clk;
  logic reset_n;

  uart_tx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];    // expected data_out after each read strobe
  logic [7:0] model_q[$];  // reference FIFO contents
  logic [7:0] model_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: each read strobe seen on an edge yields one scoreboard compare.
  always @(posedge clk) begin
    if (reset_n && !bus.fifo_read_n) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_data: got 0x%0h expected <no entry queued>", bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          failures++;
          $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", bus.data_out, e, $time);
        end else begin
          $display("ok   rd_data: 0x%0h", bus.data_out);
        end
      end
    end
  end

  // One clock of stimulus; starts and ends at posedge+1. Updates the model,
  // queues the expected read result and checks status flags after the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c);
    bit rd_acc, wr_acc, exp_ovf;
    rd_acc  = !c && r && (model_q.size() > 0);
    wr_acc  = !c && w && ((model_q.size() < 16) || rd_acc);
    exp_ovf = !c && w && !wr_acc;
    if (c) model_q.delete();
    if (rd_acc) model_dout = model_q.pop_front();
    if (wr_acc) model_q.push_back(d);
    if (r) exp_q.push_back(model_dout);

    bus.fifo_write_n = ~w;
    bus.data_in      = d;
    bus.fifo_read_n  = ~r;
    bus.fifo_clr     = c;
    @(posedge clk);
    #1;
    bus.fifo_write_n = 1'b1;
    bus.fifo_read_n  = 1'b1;
    bus.fifo_clr     = 1'b0;
    chk("count", int'(bus.fifo_count), model_q.size());
    chk("empty", int'(bus.fifo_empty), int'(model_q.size() == 0));
    chk("full",  int'(bus.fifo_full),  int'(model_q.size() == 16));
    chk("ovf",   int'(bus.overflow),   int'(exp_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.fifo_clr     = 1'b0;
    bus.fifo_write_n = 1'b1;
    bus.fifo_read_n  = 1'b1;
    bus.data_in      = 8'h00;
    model_dout       = 8'h00;

    // Reset values while held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",  int'(bus.data_out),   0);
    chk("rst_empty", int'(bus.fifo_empty), 1);
    chk("rst_full",  int'(bus.fifo_full),  0);
    chk("rst_count", int'(bus.fifo_count), 0);
    chk("rst_ovf",   int'(bus.overflow),   0);
    reset_n = 1'b1;

    // Asynchronous reset after 5 writes clears count without a clock edge.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    chk("pre_arst_count", int'(bus.fifo_count), 5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", int'(bus.fifo_count), 0);
    chk("arst_empty", int'(bus.fifo_empty), 1);
    model_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Ordering: three writes, three single-cycle reads spaced 4 cycles apart.
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b1, 8'h0F, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ord0", int'(bus.data_out), 8'h55);
    idle(3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ord1", int'(bus.data_out), 8'hA3);
    idle(3);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ord2", int'(bus.data_out), 8'h0F);
    chk("ord_empty", int'(bus.fifo_empty), 1);

    // Fill to full, overflow, drain.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("full_flag", int'(bus.fifo_full), 1);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_pulse", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.fifo_count), 16);
    idle(1);
    chk("ovf_gone", int'(bus.overflow), 0);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_last", int'(bus.data_out), 8'h0F);

    // Wrap-around: 3 rounds of 10 writes then 10 reads.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h20 + 10 * k + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap_count", int'(bus.fifo_count), 0);
    end
    chk("wrap_last", int'(bus.data_out), 8'h3D);

    // Empty + simultaneous read/write: no fall-through.
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("sim_e_count", int'(bus.fifo_count), 1);
    chk("sim_e_dout",  int'(bus.data_out), 8'h3D);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sim_e_read", int'(bus.data_out), 8'h77);

    // Full + simultaneous read/write: oldest out, no overflow.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hCC, 1'b1, 1'b0);
    chk("sim_f_count", int'(bus.fifo_count), 16);
    chk("sim_f_ovf",   int'(bus.overflow), 0);
    chk("sim_f_dout",  int'(bus.data_out), 8'h80);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("sim_f_last", int'(bus.data_out), 8'hCC);

    // Flush overrides a write; then read while empty changes nothing.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("clr_count", int'(bus.fifo_count), 0);
    chk("clr_empty", int'(bus.fifo_empty), 1);
    chk("clr_dout",  int'(bus.data_out), 8'hCC);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("und_dout",  int'(bus.data_out), 8'hCC);
    chk("und_count", int'(bus.fifo_count), 0);

    // Every queued expectation must have been consumed by the monitor.
    @(posedge clk);
    #2;
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
